fixed_to_fp_pipe: RTL
=====================

FIXED_TO_FP_PIPE -- requirements
Module: fixed_to_fp_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter IN_W, default 32: fixed-point input width in bits.
REQ-003 Parameter FRAC_W, default 16: fractional bits of the input; 0 <= FRAC_W < IN_W.
REQ-004 Parameter SIGNED, default 1: 1 = two's-complement input, 0 = unsigned input.
REQ-005 Parameter EXP_W, default 8: exponent width of the output format.
REQ-006 Parameter MAN_W, default 23: stored mantissa width of the output format.
REQ-007 Parameter RND_RNE, default 1: 1 = round-to-nearest-even, 0 = truncate toward zero.
REQ-008 Port clk, input, 1: rising-edge clock.
REQ-009 Port rst_n, input, 1: asynchronous active-low reset.
REQ-010 Port A_vld, input, 1: input word valid.
REQ-011 Port A_dat, input, IN_W: fixed-point input word.
REQ-012 Port A_rdy, output, 1: block accepts A_dat this cycle.
REQ-013 Port P_vld, output, 1: result valid.
REQ-014 Port P_dat, output, 1+EXP_W+MAN_W: packed float {sign, exponent, mantissa}.
REQ-015 Port P_inexact, output, 1: result differs from the exact input value (rounding, overflow or flush).
REQ-016 Port P_rdy, input, 1: downstream accepts P_dat this cycle.

Function
REQ-017 A transfer SHALL occur on a clk edge where vld and rdy are both high; no data is dropped or duplicated under any P_rdy pattern.
REQ-018 The pipeline SHALL have 3 register stages: S1 sign and magnitude, S2 leading-one detect and normalising left shift, S3 round, exponent adjust and pack.
REQ-019 Latency from input transfer to P_vld SHALL be exactly 3 cycles when P_rdy is held high; throughput SHALL be 1 word/cycle.
REQ-020 The global advance SHALL be en = !P_vld | P_rdy; A_rdy = en; the stage valids and data advance only when en is high.
REQ-021 A_rdy SHALL NOT depend combinationally on A_vld.
REQ-022 When P_vld is high and P_rdy is low, P_dat and P_inexact SHALL be held stable.
REQ-023 The represented value SHALL be A_dat * 2^-FRAC_W; the magnitude SHALL be held as an IN_W-bit unsigned value so that the most negative signed input converts correctly.
REQ-024 Exponent SHALL be (p - FRAC_W) + (2^(EXP_W-1) - 1), where p is the index of the leading one of the magnitude.
REQ-025 Mantissa SHALL be the MAN_W bits below the leading one; bits below those are guard and sticky for rounding.
REQ-026 Under RNE, a mantissa carry-out SHALL increment the exponent and clear the mantissa.
REQ-027 An input of zero SHALL produce +0 with P_inexact = 0.
REQ-028 A biased exponent >= 2^EXP_W - 1 after rounding SHALL produce signed infinity (exp all ones, man 0) with P_inexact = 1.
REQ-029 A biased exponent <= 0 SHALL flush to signed zero with P_inexact = 1; subnormals are not generated.
REQ-030 Width rules: internal exponent arithmetic SHALL be signed, with width max(EXP_W, $clog2(IN_W)) + 2; when MAN_W + 1 >= IN_W, no rounding occurs and P_inexact comes only from REQ-028 and REQ-029.

Reset
REQ-031 On rst_n low, all stage valids, P_vld and P_inexact SHALL clear to 0 immediately and P_dat SHALL clear to 0; A_rdy SHALL read 1 while in reset.
REQ-032 Words in flight at reset SHALL be discarded; the first word accepted after rst_n rises SHALL emerge 3 cycles later.

Structure
REQ-033 Package fixed_to_fp_pkg SHALL hold the stage-record struct typedefs, the BIAS function and the rounding-mode constants.
REQ-034 Leading-one detection SHALL be one sub-module, lzc (parametrised width, combinational, count output); everything else stays in fixed_to_fp_pipe.

Verification
REQ-035 Default parameters, P_rdy = 1: A = 0x00010000 -> P = 0x3F800000, inexact 0, 3 cycles after transfer; A = 0xFFFF0000 -> 0xBF800000.
REQ-036 A = 0x80000000 -> 0xC7000000 (-32768.0), inexact 0; A = 0x00000000 -> 0x00000000, inexact 0.
REQ-037 A = 0x7FFFFFFF, RND_RNE = 1 -> 0x47000000, inexact 1; the same input with RND_RNE = 0 -> 0x46FFFFFF, inexact 1.
REQ-038 IN_W = 32, FRAC_W = 0, EXP_W = 5, MAN_W = 10: A = 70000 -> 0x7C00, inexact 1; A = 1024 -> 0x6400, inexact 0.
REQ-039 Stream 1000 random words with random A_vld and P_rdy toggling -> output sequence equals the reference model in order, with P_dat stable while stalled.
REQ-040 Assert rst_n low with 3 words in flight -> P_vld is 0 in the same cycle; after release, the next word is the only output.

Source files
------------

// File: rtl/fixed_to_fp_pkg.sv
// Shared types and helpers for the fixed-point to floating-point converter.
// Holds the per-stage control record, rounding-mode encodings and exponent bias.
package fixed_to_fp_pkg;

    localparam logic RND_TRUNC        = 1'b0;
    localparam logic RND_NEAREST_EVEN = 1'b1;

    typedef struct packed {
        logic vld;
        logic sign;
    } stage_ctl_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fixed_to_fp_pipe_lzc.sv
// Leading-zero counter: number of zero bits above the most significant one.
// Combinational, zero latency; an all-zero input returns WIDTH.
// No flow control; purely a function of dat.
module lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] dat,
    output logic [CNT_W-1:0] cnt
);

    logic found;

    always_comb begin
        cnt   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (dat[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fixed_to_fp_pipe.sv
// Converts a fixed-point word to a packed {sign, exponent, mantissa} float.
// Latency 3 cycles (sign/magnitude, normalise, round/pack), 1 word/cycle.
// One global enable stalls every stage while the output is held and not taken.
module fixed_to_fp_pipe
    import fixed_to_fp_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int FRAC_W  = 16,
    parameter int SIGNED  = 1,
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int RND_RNE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     A_vld,
    input  logic [IN_W-1:0]          A_dat,
    output logic                     A_rdy,
    output logic                     P_vld,
    output logic [EXP_W+MAN_W:0]     P_dat,
    output logic                     P_inexact,
    input  logic                     P_rdy
);

    localparam int EW    = ((EXP_W > $clog2(IN_W)) ? EXP_W : $clog2(IN_W)) + 2;
    localparam int LZ_W  = $clog2(IN_W + 1);
    localparam int EXT_W = IN_W + MAN_W + 1;
    localparam logic USE_RNE = (RND_RNE != 0) ? RND_NEAREST_EVEN : RND_TRUNC;
    localparam logic signed [EW-1:0] EXP_BASE = EW'(IN_W - 1 - FRAC_W + bias(EXP_W));
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

    logic en;
    assign en    = !P_vld || P_rdy;
    assign A_rdy = en;

    // S1: sign and magnitude; IN_W unsigned bits hold the most negative input exactly
    logic            neg_d;
    logic [IN_W-1:0] mag_d;
    stage_ctl_t      s1_ctl;
    logic [IN_W-1:0] s1_mag;

    assign neg_d = (SIGNED != 0) && A_dat[IN_W-1];
    assign mag_d = neg_d ? -A_dat : A_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctl <= '0;
            s1_mag <= '0;
        end else if (en) begin
            s1_ctl <= '{vld: A_vld, sign: neg_d};
            s1_mag <= mag_d;
        end
    end

    // S2: normalise so the leading one sits at the MSB
    logic [LZ_W-1:0]        lz;
    stage_ctl_t             s2_ctl;
    logic [IN_W-1:0]        s2_norm;
    logic signed [EW-1:0]   s2_exp;

    lzc #(.WIDTH(IN_W)) u_lzc (
        .dat (s1_mag),
        .cnt (lz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ctl  <= '0;
            s2_norm <= '0;
            s2_exp  <= '0;
        end else if (en) begin
            s2_ctl  <= s1_ctl;
            s2_norm <= s1_mag << lz;
            s2_exp  <= EXP_BASE - $signed(EW'(lz));
        end
    end

    // S3: round, adjust exponent, handle zero/overflow/underflow, pack
    logic [EXT_W-1:0]       ext;
    logic [MAN_W-1:0]       mant_t;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [MAN_W:0]         mant_r;
    logic signed [EW-1:0]   exp_r;
    logic [EXP_W+MAN_W:0]   res_dat;
    logic                   res_inx;

    assign ext      = {s2_norm[IN_W-2:0], {(MAN_W + 2){1'b0}}};
    assign mant_t   = ext[EXT_W-1 -: MAN_W];
    assign guard    = ext[EXT_W-1-MAN_W];
    assign sticky   = |ext[EXT_W-2-MAN_W:0];
    assign round_up = (USE_RNE == RND_NEAREST_EVEN) && guard && (sticky || mant_t[0]);
    assign mant_r   = {1'b0, mant_t} + {{MAN_W{1'b0}}, round_up};
    assign exp_r    = s2_exp + $signed({{(EW - 1){1'b0}}, mant_r[MAN_W]});

    always_comb begin
        res_dat = '0;
        res_inx = 1'b0;
        if (!s2_norm[IN_W-1]) begin
            res_dat = '0;
            res_inx = 1'b0;
        end else if (exp_r >= EXP_MAX) begin
            res_dat = {s2_ctl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_inx = 1'b1;
        end else if (exp_r < EXP_ONE) begin
            res_dat = {s2_ctl.sign, {(EXP_W + MAN_W){1'b0}}};
            res_inx = 1'b1;
        end else begin
            res_dat = {s2_ctl.sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
            res_inx = guard || sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P_vld     <= 1'b0;
            P_dat     <= '0;
            P_inexact <= 1'b0;
        end else if (en) begin
            P_vld     <= s2_ctl.vld;
            P_dat     <= res_dat;
            P_inexact <= res_inx;
        end
    end

endmodule
